prach_fft_frame_ctrl: RTL and testbench

PRACH_FFT_FRAME_CTRL -- requirements
Module: prach_fft_frame_ctrl

---
 rtl/prach_fft_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_prach_fft_frame_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_fft_frame_ctrl.sv
// PRACH FFT frame controller.
// Splits a burst of cfg_num_frames frames of NUM_FFT_LENGTH samples each out of a
// sample stream. It passes the samples through a two-stage pipeline and marks each
// frame start with sync_ahead_out and sync_out. At the end of the burst it drains
// for NUM_FLUSH cycles and then pulses done.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start, cfg_num_frames burst request; frame count sampled when start is accepted
//   din_dr/din_di/din_dv  input sample (real, imag) and valid
//   dout_dr/dout_di/dout_dv output sample, two cycles after input
//   sync_ahead_out        one cycle before sync_out
//   sync_out              first output sample of a frame
//   tw_addr               frame sample index mod NUM_FFT_LENGTH/2, aligned with dout
//   busy                  burst in progress (ARM/RUN/FLUSH)
//   done, err_overrun, err_gap  single-cycle status pulses
module prach_fft_frame_ctrl #(
  parameter int unsigned NUM_FFT_LENGTH = 64,
  parameter int unsigned NUM_FLUSH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        cfg_num_frames,
  input  logic [17:0]                       din_dr,
  input  logic [17:0]                       din_di,
  input  logic                              din_dv,
  output logic [17:0]                       dout_dr,
  output logic [17:0]                       dout_di,
  output logic                              dout_dv,
  output logic                              sync_out,
  output logic                              sync_ahead_out,
  output logic [$clog2(NUM_FFT_LENGTH)-2:0] tw_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              err_overrun,
  output logic                              err_gap
);

  localparam int unsigned CW = $clog2(NUM_FFT_LENGTH);
  localparam int unsigned FW = (NUM_FLUSH > 1) ? $clog2(NUM_FLUSH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_FFT_LENGTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(NUM_FLUSH - 1);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFlush} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    frames_left;
  logic [FW-1:0] flush_cnt;

  // Pipeline stage 1; sync_ahead_out doubles as the stage-1 frame-start flag.
  logic [17:0]   s1_dr;
  logic [17:0]   s1_di;
  logic          s1_dv;
  logic [CW-2:0] s1_tw;

  logic accept;
  logic first_smp;

  assign accept    = din_dv && ((state == StArm) || (state == StRun));
  // In ARM the counter is always 0, so a zero count marks frame index 0 in both states.
  assign first_smp = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      cnt            <= '0;
      frames_left    <= '0;
      flush_cnt      <= '0;
      s1_dr          <= '0;
      s1_di          <= '0;
      s1_dv          <= 1'b0;
      s1_tw          <= '0;
      dout_dr        <= '0;
      dout_di        <= '0;
      dout_dv        <= 1'b0;
      sync_out       <= 1'b0;
      sync_ahead_out <= 1'b0;
      tw_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
      err_gap        <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_gap     <= 1'b0;
      err_overrun <= start && busy;

      // Stage 1: only accepted samples are captured.
      s1_dv          <= accept;
      sync_ahead_out <= accept && first_smp;
      if (accept) begin
        s1_dr <= din_dr;
        s1_di <= din_di;
        s1_tw <= cnt[CW-2:0];
      end

      // Stage 2: dout holds its last value when nothing valid arrives.
      dout_dv  <= s1_dv;
      sync_out <= sync_ahead_out;
      tw_addr  <= s1_dv ? s1_tw : '0;
      if (s1_dv) begin
        dout_dr <= s1_dr;
        dout_di <= s1_di;
      end

      unique case (state)
        StIdle: begin
          if (start && (cfg_num_frames != '0)) begin
            frames_left <= cfg_num_frames;
            cnt         <= '0;
            state       <= StArm;
            busy        <= 1'b1;
          end
        end
        StArm: begin
          if (din_dv) begin
            cnt   <= CW'(1);
            state <= StRun;
          end
        end
        StRun: begin
          if (din_dv) begin
            if (cnt == CNT_LAST) begin
              cnt         <= '0;
              frames_left <= frames_left - 8'd1;
              if (frames_left == 8'd1) begin
                state     <= StFlush;
                flush_cnt <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (cnt != '0) begin
            // Gap inside a frame: drop the rest of it and wait for a fresh frame start.
            err_gap <= 1'b1;
            cnt     <= '0;
            state   <= StArm;
          end
        end
        StFlush: begin
          if (flush_cnt == FLUSH_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prach_fft_frame_ctrl.sv
module tb_prach_fft_frame_ctrl;

  localparam int N  = 8;
  localparam int NF = 4;
  localparam int TW = $clog2(N) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_FRAME = 2;
  localparam int M_FLUSH = 3;

  localparam int EV_SYNCA = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_GAP   = 2;
  localparam int EV_OVR   = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_num_frames;
  logic [17:0]   din_dr;
  logic [17:0]   din_di;
  logic          din_dv;
  logic [17:0]   dout_dr;
  logic [17:0]   dout_di;
  logic          dout_dv;
  logic          sync_out;
  logic          sync_ahead_out;
  logic [TW-1:0] tw_addr;
  logic          busy;
  logic          done;
  logic          err_overrun;
  logic          err_gap;

  prach_fft_frame_ctrl #(
    .NUM_FFT_LENGTH(N),
    .NUM_FLUSH     (NF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_num_frames(cfg_num_frames),
    .din_dr        (din_dr),
    .din_di        (din_di),
    .din_dv        (din_dv),
    .dout_dr       (dout_dr),
    .dout_di       (dout_di),
    .dout_dv       (dout_dv),
    .sync_out      (sync_out),
    .sync_ahead_out(sync_ahead_out),
    .tw_addr       (tw_addr),
    .busy          (busy),
    .done          (done),
    .err_overrun   (err_overrun),
    .err_gap       (err_gap)
  );

  typedef struct {
    int          cyc;
    logic [17:0] dr;
    logic [17:0] di;
    int          tw;
    bit          sync;
  } smp_t;

  typedef struct {
    int cyc;
    int kind;
  } evt_t;

  smp_t exp_q[$];
  evt_t evt_q[$];
  bit   exp_busy[int];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: burst bookkeeping in plain integers.
  int m_mode   = M_IDLE;
  int m_frames = 0;
  int m_pos    = 0;
  int m_flush  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void push_evt(int c, int k);
    evt_t e;
    e.cyc  = c;
    e.kind = k;
    evt_q.push_back(e);
  endfunction

  // Predicts what the DUT does with the inputs presented during cycle 'cyc'.
  task automatic model_step(bit s, int cfg, bit dv, logic [17:0] dr, logic [17:0] di);
    int   idx;
    smp_t e;
    idx = -1;
    if (s && m_mode != M_IDLE) push_evt(cyc + 1, EV_OVR);
    if (m_mode == M_IDLE) begin
      if (s && cfg != 0) begin
        m_frames = cfg;
        m_pos    = 0;
        m_mode   = M_WAIT;
      end
    end else if (m_mode == M_WAIT) begin
      if (dv) begin
        idx    = 0;
        m_pos  = 1;
        m_mode = M_FRAME;
      end
    end else if (m_mode == M_FRAME) begin
      if (dv) begin
        idx = m_pos;
        m_pos++;
        if (m_pos == N) begin
          m_pos = 0;
          m_frames--;
          if (m_frames == 0) begin
            m_mode  = M_FLUSH;
            m_flush = NF;
          end
        end
      end else if (m_pos != 0) begin
        push_evt(cyc + 1, EV_GAP);
        m_pos  = 0;
        m_mode = M_WAIT;
      end
    end else begin
      m_flush--;
      if (m_flush == 0) begin
        push_evt(cyc + 1, EV_DONE);
        m_mode = M_IDLE;
      end
    end
    if (idx >= 0) begin
      e.cyc  = cyc + 2;
      e.dr   = dr;
      e.di   = di;
      e.tw   = idx % (N / 2);
      e.sync = (idx == 0);
      exp_q.push_back(e);
      if (idx == 0) push_evt(cyc + 1, EV_SYNCA);
    end
    exp_busy[cyc + 1] = (m_mode != M_IDLE);
  endtask

  task automatic drive(bit s, int cfg, bit dv, logic [17:0] dr);
    @(posedge clk);
    #1;
    start          = s;
    cfg_num_frames = cfg[7:0];
    din_dv         = dv;
    din_dr         = dr;
    din_di         = 18'($urandom);
    model_step(s, cfg, dv, din_dr, din_di);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 18'($urandom));
  endtask

  task automatic samples(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1, 18'($urandom));
  endtask

  task automatic do_reset(int hold);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    start  = 1'b0;
    din_dv = 1'b1;
    exp_q.delete();
    evt_q.delete();
    exp_busy.delete();
    m_mode = M_IDLE;
    m_pos  = 0;
    repeat (hold) @(posedge clk);
    #1;
    rst    = 1'b0;
    din_dv = 1'b0;
    model_step(1'b0, 0, 1'b0, din_dr, din_di);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  logic [17:0] last_dr = '0;
  logic [17:0] last_di = '0;
  bit          sigs[4];
  string       names[4] = '{"sync_ahead_out", "done", "err_gap", "err_overrun"};
  int          hit;
  smp_t        got;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      n_cmp++;
      if ({dout_dr, dout_di, dout_dv, sync_out, sync_ahead_out, tw_addr, busy, done,
           err_overrun, err_gap} != '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got dr=%h di=%h dv=%0b sync=%0b sa=%0b tw=%0d busy=%0b done=%0b ovr=%0b gap=%0b, required all 0",
                 cyc, dout_dr, dout_di, dout_dv, sync_out, sync_ahead_out, tw_addr, busy,
                 done, err_overrun, err_gap);
      end
      last_dr = '0;
      last_di = '0;
    end else begin
      if (dout_dv) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL dout_unexpected cycle %0d: got dout_dv=1 dr=%h, required no sample",
                   cyc, dout_dr);
        end else begin
          got = exp_q.pop_front();
          if (got.cyc != cyc || got.dr != dout_dr || got.di != dout_di ||
              got.tw != int'(tw_addr) || got.sync != sync_out) begin
            n_fail++;
            $display("FAIL dout cycle %0d: got dr=%h di=%h tw=%0d sync=%0b, required dr=%h di=%h tw=%0d sync=%0b at cycle %0d",
                     cyc, dout_dr, dout_di, tw_addr, sync_out, got.dr, got.di, got.tw,
                     got.sync, got.cyc);
          end
        end
        last_dr = dout_dr;
        last_di = dout_di;
      end else begin
        n_cmp++;
        if (sync_out || tw_addr != '0 || dout_dr != last_dr || dout_di != last_di ||
            (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
          n_fail++;
          $display("FAIL idle_hold cycle %0d: got sync=%0b tw=%0d dr=%h di=%h, required sync=0 tw=0 dr=%h di=%h and no due sample",
                   cyc, sync_out, tw_addr, dout_dr, dout_di, last_dr, last_di);
        end
      end
      sigs[EV_SYNCA] = sync_ahead_out;
      sigs[EV_DONE]  = done;
      sigs[EV_GAP]   = err_gap;
      sigs[EV_OVR]   = err_overrun;
      for (int k = 0; k < 4; k++) begin
        hit = -1;
        foreach (evt_q[i]) if (evt_q[i].cyc == cyc && evt_q[i].kind == k) hit = i;
        if (sigs[k] || hit >= 0) begin
          n_cmp++;
          if (sigs[k] != (hit >= 0)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0b, required %0b", names[k], cyc, sigs[k],
                     hit >= 0);
          end
          if (hit >= 0) evt_q.delete(hit);
        end
      end
      if (exp_busy.exists(cyc)) begin
        n_cmp++;
        if (busy != exp_busy[cyc]) begin
          n_fail++;
          $display("FAIL busy cycle %0d: got %0b, required %0b", cyc, busy, exp_busy[cyc]);
        end
        exp_busy.delete(cyc);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_num_frames = '0;
    din_dr         = '0;
    din_di         = '0;
    din_dv         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_step(1'b0, 0, 1'b0, din_dr, din_di);
    idle(2);

    // Single frame, samples 1..8.
    drive(1'b1, 1, 1'b0, 18'd0);
    for (int i = 1; i <= N; i++) drive(1'b0, 0, 1'b1, 18'(i));
    idle(10);

    // Three back-to-back frames.
    drive(1'b1, 3, 1'b0, 18'd0);
    samples(3 * N);
    idle(10);

    // Gap after sample 5 of frame 0, then two complete frames.
    drive(1'b1, 2, 1'b0, 18'd0);
    samples(5);
    drive(1'b0, 0, 1'b0, 18'($urandom));
    samples(2 * N);
    idle(10);

    // Start while running.
    drive(1'b1, 2, 1'b0, 18'd0);
    samples(3);
    drive(1'b1, 5, 1'b1, 18'($urandom));
    samples(2 * N - 4);
    idle(10);

    // Reset at sample 4 of frame 1, then a fresh one-frame burst.
    drive(1'b1, 2, 1'b0, 18'd0);
    samples(N + 3);
    do_reset(2);
    idle(3);
    drive(1'b1, 1, 1'b0, 18'd0);
    samples(N);
    idle(10);

    // Zero-frame request is ignored.
    drive(1'b1, 0, 1'b1, 18'($urandom));
    samples(3);
    idle(5);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 16) == 0, int'($urandom % 4), ($urandom % 10) != 0, 18'($urandom));
    end
    idle(20);

    n_cmp++;
    if (exp_q.size() != 0 || evt_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d samples and %0d events outstanding, required 0 and 0",
               exp_q.size(), evt_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
